// File: rtl/alu_ctrl_decode.sv
// Decode-stage ALU control generator for the 16-bit WISC core. It decodes an
// instruction into the execute-stage ALU control word and holds it in an ID/EX register.
module alu_ctrl_decode #(
    parameter int OP_W   = 4,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [15:0]       instr,
    input  logic              stall,
    input  logic              flush,
    output logic              ex_valid,
    output logic [OP_W-1:0]   alu_op,
    output logic              inv_a,
    output logic              inv_b,
    output logic              cin,
    output logic              sign,
    output logic              b_sel,
    output logic [DATA_W-1:0] imm,
    output logic              alu_en,
    output logic              halted
);

    localparam logic [OP_W-1:0] OP_ADD = OP_W'(4);
    localparam logic [OP_W-1:0] OP_XOR = OP_W'(6);
    localparam logic [OP_W-1:0] OP_AND = OP_W'(7);
    localparam logic [OP_W-1:0] OP_SEQ = OP_W'(8);
    localparam logic [OP_W-1:0] OP_SLT = OP_W'(9);
    localparam logic [OP_W-1:0] OP_SLE = OP_W'(10);
    localparam logic [OP_W-1:0] OP_SCO = OP_W'(11);
    localparam logic [OP_W-1:0] OP_BTR = OP_W'(12);

    logic [4:0] opcode;
    logic [1:0] func;
    logic       isHalt;
    logic       unusedRegFields;

    assign opcode          = instr[15:11];
    assign func            = instr[1:0];
    assign isHalt          = (opcode == 5'b00000);
    assign unusedRegFields = ^instr[10:5];

    // Combinational decode of the instruction currently in ID.
    logic [OP_W-1:0]   decOp;
    logic              decInvA;
    logic              decInvB;
    logic              decCin;
    logic              decSign;
    logic              decBSel;
    logic              decAluEn;
    logic              immSext;
    logic              immZext;
    logic [DATA_W-1:0] decImm;

    always_comb begin
        decOp    = '0;
        decInvA  = 1'b0;
        decInvB  = 1'b0;
        decCin   = 1'b0;
        decSign  = 1'b1;
        decBSel  = 1'b0;
        decAluEn = 1'b1;
        immSext  = 1'b0;
        immZext  = 1'b0;
        case (opcode)
            5'b11011: begin
                case (func)
                    2'b00: decOp = OP_ADD;
                    2'b01: begin
                        decOp   = OP_ADD;
                        decInvA = 1'b1;
                        decCin  = 1'b1;
                    end
                    2'b10: decOp = OP_XOR;
                    default: begin
                        decOp   = OP_AND;
                        decInvB = 1'b1;
                    end
                endcase
            end
            5'b11010: decOp = OP_W'(func);
            5'b01000: begin
                decOp   = OP_ADD;
                decBSel = 1'b1;
                immSext = 1'b1;
            end
            5'b01001: begin
                decOp   = OP_ADD;
                decInvA = 1'b1;
                decCin  = 1'b1;
                decBSel = 1'b1;
                immSext = 1'b1;
            end
            5'b01010: begin
                decOp   = OP_XOR;
                decBSel = 1'b1;
                immZext = 1'b1;
            end
            5'b01011: begin
                decOp   = OP_AND;
                decInvB = 1'b1;
                decBSel = 1'b1;
                immZext = 1'b1;
            end
            // Shift-immediates: the ALU only looks at imm[3:0] for the count.
            5'b10100, 5'b10101, 5'b10110, 5'b10111: begin
                decOp   = OP_W'(opcode[1:0]);
                decBSel = 1'b1;
                immZext = 1'b1;
            end
            5'b10000, 5'b10001, 5'b10011: begin
                decOp   = OP_ADD;
                decBSel = 1'b1;
                immSext = 1'b1;
            end
            5'b11100: begin
                decOp   = OP_SEQ;
                decInvB = 1'b1;
                decCin  = 1'b1;
            end
            5'b11101: begin
                decOp   = OP_SLT;
                decInvB = 1'b1;
                decCin  = 1'b1;
            end
            5'b11110: begin
                decOp   = OP_SLE;
                decInvB = 1'b1;
                decCin  = 1'b1;
            end
            5'b11111: begin
                decOp   = OP_SCO;
                decSign = 1'b0;
            end
            5'b11001: decOp = OP_BTR;
            default: begin
                // HALT, NOP, branches, jumps, LBI/SLBI etc: all-zero word.
                decSign  = 1'b0;
                decAluEn = 1'b0;
            end
        endcase
    end

    for (genvar gi = 0; gi < DATA_W; gi++) begin : gImm
        if (gi < 5) begin : gLow
            assign decImm[gi] = instr[gi] & (immSext | immZext);
        end else begin : gHigh
            assign decImm[gi] = instr[4] & immSext;
        end
    end

    // ID/EX register.
    logic              exValidReg, exValidNext;
    logic [OP_W-1:0]   aluOpReg, aluOpNext;
    logic              invAReg, invANext;
    logic              invBReg, invBNext;
    logic              cinReg, cinNext;
    logic              signReg, signNext;
    logic              bSelReg, bSelNext;
    logic [DATA_W-1:0] immReg, immNext;
    logic              aluEnReg, aluEnNext;
    logic              haltedReg, haltedNext;

    always_comb begin
        exValidNext = exValidReg;
        aluOpNext   = aluOpReg;
        invANext    = invAReg;
        invBNext    = invBReg;
        cinNext     = cinReg;
        signNext    = signReg;
        bSelNext    = bSelReg;
        immNext     = immReg;
        aluEnNext   = aluEnReg;
        haltedNext  = haltedReg;
        if (flush || !stall) begin
            exValidNext = 1'b0;
            aluOpNext   = '0;
            invANext    = 1'b0;
            invBNext    = 1'b0;
            cinNext     = 1'b0;
            signNext    = 1'b0;
            bSelNext    = 1'b0;
            immNext     = '0;
            aluEnNext   = 1'b0;
            // A flush on the HALT edge discards it, so halted is never set then.
            if (!flush && !haltedReg && id_valid) begin
                exValidNext = 1'b1;
                aluOpNext   = decOp;
                invANext    = decInvA;
                invBNext    = decInvB;
                cinNext     = decCin;
                signNext    = decSign;
                bSelNext    = decBSel;
                immNext     = decImm;
                aluEnNext   = decAluEn;
                haltedNext  = isHalt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exValidReg <= 1'b0;
            aluOpReg   <= '0;
            invAReg    <= 1'b0;
            invBReg    <= 1'b0;
            cinReg     <= 1'b0;
            signReg    <= 1'b0;
            bSelReg    <= 1'b0;
            immReg     <= '0;
            aluEnReg   <= 1'b0;
            haltedReg  <= 1'b0;
        end else begin
            exValidReg <= exValidNext;
            aluOpReg   <= aluOpNext;
            invAReg    <= invANext;
            invBReg    <= invBNext;
            cinReg     <= cinNext;
            signReg    <= signNext;
            bSelReg    <= bSelNext;
            immReg     <= immNext;
            aluEnReg   <= aluEnNext;
            haltedReg  <= haltedNext;
        end
    end

    assign ex_valid = exValidReg;
    assign alu_op   = aluOpReg;
    assign inv_a    = invAReg;
    assign inv_b    = invBReg;
    assign cin      = cinReg;
    assign sign     = signReg;
    assign b_sel    = bSelReg;
    assign imm      = immReg;
    assign alu_en   = aluEnReg;
    assign halted   = haltedReg;

endmodule

// File: tb/tb_alu_ctrl_decode.sv
// Bench for alu_ctrl_decode: directed vectors with literal expectations plus a
// behavioural model compared against the DUT on every falling edge.
module tb_alu_ctrl_decode;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 1'b0;
    logic [15:0] instr = 16'h0000;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        ex_valid, inv_a, inv_b, cin, sign, b_sel, alu_en, halted;
    logic [3:0]  alu_op;
    logic [15:0] imm;

    int asserts = 0;
    int fails   = 0;

    always #5 clk = ~clk;

    alu_ctrl_decode #(.OP_W(4), .DATA_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .instr(instr),
        .stall(stall), .flush(flush), .ex_valid(ex_valid), .alu_op(alu_op),
        .inv_a(inv_a), .inv_b(inv_b), .cin(cin), .sign(sign), .b_sel(b_sel),
        .imm(imm), .alu_en(alu_en), .halted(halted)
    );

    typedef struct packed {
        logic        aluEn;
        logic [3:0]  op;
        logic        invA;
        logic        invB;
        logic        cin;
        logic        sign;
        logic        bSel;
        logic [15:0] imm;
    } ctrl_t;

    ctrl_t dutCtrl;
    assign dutCtrl = {alu_en, alu_op, inv_a, inv_b, cin, sign, b_sel, imm};

    function automatic ctrl_t mk(input logic en, input logic [3:0] op, input logic ia,
                                 input logic ib, input logic ci, input logic sg,
                                 input logic bs, input logic [15:0] im);
        return {en, op, ia, ib, ci, sg, bs, im};
    endfunction

    // Expected control word from the instruction-class rules.
    function automatic ctrl_t expectCtrl(input logic [15:0] ins);
        ctrl_t      c;
        logic [4:0] op5;
        logic [1:0] f;
        logic [1:0] kind;
        logic       arith;
        logic [15:0] sx;
        logic [15:0] zx;
        op5   = ins[15:11];
        f     = ins[1:0];
        sx    = {{11{ins[4]}}, ins[4:0]};
        zx    = {11'b0, ins[4:0]};
        c     = '0;
        arith = 1'b0;
        kind  = 2'd0;
        if (op5 == 5'b11011) begin
            arith = 1'b1;
            kind  = f;
        end else if (op5[4:2] == 3'b010) begin
            arith  = 1'b1;
            kind   = op5[1:0];
            c.bSel = 1'b1;
            c.imm  = op5[1] ? zx : sx;
        end
        if (arith) begin
            c.aluEn = 1'b1;
            c.sign  = 1'b1;
            c.op    = (kind == 2'd2) ? 4'd6 : (kind == 2'd3) ? 4'd7 : 4'd4;
            c.invA  = (kind == 2'd1);
            c.cin   = (kind == 2'd1);
            c.invB  = (kind == 2'd3);
        end else if (op5 == 5'b11010) begin
            c.aluEn = 1'b1;
            c.sign  = 1'b1;
            c.op    = {2'b00, f};
        end else if (op5[4:2] == 3'b101) begin
            c.aluEn = 1'b1;
            c.sign  = 1'b1;
            c.op    = {2'b00, op5[1:0]};
            c.bSel  = 1'b1;
            c.imm   = zx;
        end else if (op5 == 5'b10000 || op5 == 5'b10001 || op5 == 5'b10011) begin
            c.aluEn = 1'b1;
            c.sign  = 1'b1;
            c.op    = 4'd4;
            c.bSel  = 1'b1;
            c.imm   = sx;
        end else if (op5[4:2] == 3'b111) begin
            c.aluEn = 1'b1;
            c.op    = 4'd8 + {2'b00, op5[1:0]};
            if (op5[1:0] != 2'b11) begin
                c.sign = 1'b1;
                c.invB = 1'b1;
                c.cin  = 1'b1;
            end
        end else if (op5 == 5'b11001) begin
            c.aluEn = 1'b1;
            c.sign  = 1'b1;
            c.op    = 4'd12;
        end
        return c;
    endfunction

    // Pipeline-register model.
    logic  mValid  = 1'b0;
    logic  mHalted = 1'b0;
    logic  mReady  = 1'b0;
    ctrl_t mCtrl   = '0;

    always @(posedge clk) begin
        mReady <= 1'b1;
        if (rst) begin
            mValid  <= 1'b0;
            mCtrl   <= '0;
            mHalted <= 1'b0;
        end else if (flush) begin
            mValid <= 1'b0;
            mCtrl  <= '0;
        end else if (!stall) begin
            if (id_valid && !mHalted) begin
                mValid <= 1'b1;
                mCtrl  <= expectCtrl(instr);
                if (instr[15:11] == 5'b00000) mHalted <= 1'b1;
            end else begin
                mValid <= 1'b0;
                mCtrl  <= '0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mReady) begin
            chk("model.ex_valid", 32'(ex_valid), 32'(mValid));
            chk("model.ctrl", 32'(dutCtrl), 32'(mCtrl));
            chk("model.halted", 32'(halted), 32'(mHalted));
            chk("model.noX", 32'($isunknown({ex_valid, dutCtrl, halted})), 32'd0);
        end
    end

    task automatic step(input logic r, input logic v, input logic s, input logic fl,
                        input logic [15:0] ins);
        rst      = r;
        id_valid = v;
        stall    = s;
        flush    = fl;
        instr    = ins;
        @(posedge clk);
        #1;
        $display("txn rst=%0b v=%0b stall=%0b flush=%0b instr=%04h -> ex_valid=%0b op=%0h ia=%0b ib=%0b cin=%0b sign=%0b bsel=%0b imm=%04h en=%0b halted=%0b",
                 r, v, s, fl, ins, ex_valid, alu_op, inv_a, inv_b, cin, sign, b_sel,
                 imm, alu_en, halted);
    endtask

    ctrl_t subWord;
    logic  expEn;

    initial begin
        subWord = mk(1'b1, 4'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);

        step(1'b1, 1'b1, 1'b0, 1'b0, 16'hD94D);
        chk("reset.cycle1", 32'({ex_valid, halted, dutCtrl}), 32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'hD94D);
        chk("reset.cycle2", 32'({ex_valid, halted, dutCtrl}), 32'd0);

        step(1'b0, 1'b1, 1'b0, 1'b0, 16'hD94D);
        chk("sub.valid", 32'(ex_valid), 32'd1);
        chk("sub.word", 32'(dutCtrl), 32'(subWord));
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h423F);
        chk("addi.word", 32'(dutCtrl),
            32'(mk(1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFF)));
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h523F);
        chk("xori.word", 32'(dutCtrl),
            32'(mk(1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h001F)));
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'hE94C);
        chk("slt.word", 32'(dutCtrl),
            32'(mk(1'b1, 4'd9, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000)));
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'hF94C);
        chk("sco.word", 32'(dutCtrl),
            32'(mk(1'b1, 4'd11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000)));

        step(1'b0, 1'b1, 1'b0, 1'b0, 16'hD94D);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 16'hF94C);
            chk("stall.hold", 32'({ex_valid, dutCtrl}), 32'({1'b1, subWord}));
        end
        step(1'b0, 1'b1, 1'b1, 1'b1, 16'hF94C);
        chk("stall.flush", 32'({ex_valid, dutCtrl}), 32'd0);

        for (int op = 1; op < 32; op++) begin
            for (int f = 0; f < 4; f++) begin
                step(1'b0, 1'b1, 1'b0, 1'b0, {5'(op), 6'b001010, 3'b100, 2'(f)});
                expEn = !((op <= 7) || (op >= 12 && op <= 15) || op == 18 || op == 24);
                chk("sweep.alu_en", 32'(alu_en), 32'(expEn));
                chk("sweep.valid", 32'(ex_valid), 32'd1);
            end
        end

        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        chk("halt.state", 32'({halted, ex_valid, alu_en}), 32'b110);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'hD94D);
        chk("halt.bubble", 32'({halted, ex_valid, alu_en}), 32'b100);
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'hD94D);
        chk("halt.rstclear", 32'(halted), 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000);
        chk("halt.flushwins", 32'({halted, ex_valid}), 32'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
        chk("halt.stallnolatch", 32'(halted), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'hD94D);
        chk("idle.bubble", 32'({ex_valid, dutCtrl}), 32'd0);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_decode.md
Name: alu_ctrl_decode

Overview:
- Instruction-side counterpart of the execute-stage ALU: decodes a 16-bit WISC instruction in decode and produces the ALU control word consumed in execute.
- The control word is alu_op, inv_a, inv_b, cin, sign, b_sel and imm.
- Results are held in a registered ID/EX control stage with stall, flush and a sticky halt.

Parameters:
- OP_W, 4, width of the ALU opcode field (encoding fixed below).
- DATA_W, 16, datapath and immediate width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  instr holds a valid decoded-stage instruction this cycle.
- instr  in  16  instruction word: [15:11] opcode, [10:8] Rs, [7:5] Rt, [4:0] imm5, [1:0] func.
- stall  in  1  hold the ID/EX register contents.
- flush  in  1  replace the ID/EX contents with a bubble.
- ex_valid  out  1  the control word in the ID/EX register is live.
- alu_op  out  4  ROL=0, SLL=1, ROR=2, SRL=3, ADD=4, OR=5, XOR=6, AND=7, SEQ=8, SLT=9, SLE=A, SCO=B, BTR=C.
- inv_a  out  1  invert operand A.
- inv_b  out  1  invert operand B.
- cin  out  1  adder carry-in.
- sign  out  1  1 = signed overflow, 0 = unsigned carry-out.
- b_sel  out  1  1 = B from imm, 0 = B from Rt.
- imm  out  16  extended immediate.
- alu_en  out  1  the instruction uses the ALU result.
- halted  out  1  sticky; HALT has entered execute.

Behaviour:
- All outputs are registered and update on the rising clk edge. Latency is 1 cycle from id_valid/instr to the outputs.
- Update priority per edge is rst > flush > stall > load.
- rst: every output goes to 0, including ex_valid, alu_op, imm and halted.
- flush: load a bubble (all outputs 0 except halted, which is unchanged). flush asserted together with stall still bubbles.
- stall (without flush): all outputs hold their values. A HALT presented during stall is not latched.
- load: when halted=0 and id_valid=1, set ex_valid=1 and register the decoded word. When id_valid=0 or halted=1, load a bubble.
- HALT (00000) loads with ex_valid=1, alu_en=0 and sets halted=1 on the same edge. Further instructions are ignored until rst. A flush on the same edge as HALT wins, and halted stays 0.
- Defaults unless a rule below overrides: inv_a=inv_b=cin=0, sign=1, b_sel=0, imm=0.
- R-type ALU ops, opcode 11011 (func: 00 ADD, 01 SUB, 10 XOR, 11 ANDN):
  - ADD: op=4.
  - SUB: op=4, inv_a=1, cin=1 (computes Rt-Rs).
  - XOR: op=6.
  - ANDN: op=7, inv_b=1.
- R-type shifts, opcode 11010: op = {2'b00, func}.
- Immediate arithmetic, b_sel=1:
  - ADDI 01000: op=4.
  - SUBI 01001: op=4, inv_a=1, cin=1.
  - XORI 01010: op=6.
  - ANDNI 01011: op=7, inv_b=1.
- Immediate shifts ROLI/SLLI/RORI/SRLI (10100-10111): op = {2'b00, opcode[1:0]}, b_sel=1.
- Memory address ST 10000, LD 10001, STU 10011: op=4, b_sel=1.
- Set ops (Rs vs Rt):
  - SEQ 11100: op=8.
  - SLT 11101: op=9.
  - SLE 11110: op=A.
  - All three use inv_b=1, cin=1.
  - SCO 11111: op=B, sign=0, cin=0, no inversion.
- BTR 11001: op=C.
- Immediate extension:
  - Sign-extend imm5 for ADDI, SUBI, ST, LD, STU.
  - Zero-extend imm5 for XORI, ANDNI and the shift-immediates (the ALU uses imm[3:0] as the count).
- alu_en=1 for every opcode listed above except HALT.
- All other opcodes (NOP, siic, rti, branches, jumps, LBI, SLBI) load ex_valid=1, alu_en=0 and an all-zero control word.
- Decoding is fully specified for all 32 opcodes; no X may propagate to the outputs.

Test Plan:
- Reset: rst=1 for 2 cycles with id_valid=1, instr=0xD94D → every output 0. On the first cycle after rst falls, ex_valid=1.
- SUB 0xD94D, then ADDI 0x423F, then XORI 0x523F on consecutive cycles:
  - SUB → op=4, inv_a=1, cin=1, sign=1, b_sel=0.
  - ADDI → op=4, b_sel=1, imm=0xFFFF.
  - XORI → op=6, imm=0x001F.
  - Each appears exactly 1 cycle after presentation.
- SLT 0xE94C → op=9, inv_b=1, cin=1, sign=1. SCO 0xF94C → op=B, inv_b=0, cin=0, sign=0.
- Load SUB 0xD94D, then hold stall=1 for 3 cycles while presenting 0xF94C → outputs stay on the SUB word. Assert flush with stall → ex_valid=0 and all controls 0 next cycle.
- HALT 0x0000 followed by 0xD94D → halted=1 and ex_valid=1, alu_en=0 after HALT; then a bubble, with halted held. rst clears halted.
- Sweep all 32 opcodes × 4 func values → alu_en=0 exactly for 00000-00111, 01100-01111, 10010 and 11000; no X on any output.
